// File: rtl/audio_pkg.sv
// Shared definitions for the two-voice audio note scheduler.
package audio_pkg;

  localparam int unsigned FREQ_BITS = 5;
  localparam logic [FREQ_BITS-1:0] FREQ_SILENT = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } voice_state_e;

endpackage

// File: rtl/audio_voice.sv
// One voice: plays a note for a number of ticks, then holds silence for the articulation gap.
module audio_voice
  import audio_pkg::*;
#(
  parameter int unsigned DUR_BITS  = 8,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [FREQ_BITS-1:0] i_freq,
  input  logic [DUR_BITS-1:0]  i_dur,
  input  logic                 i_tick,
  input  logic                 i_flush,
  output logic [FREQ_BITS-1:0] o_freq,
  output logic                 o_chg,
  output logic                 o_busy
);

  localparam int unsigned GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);

  voice_state_e         r_state;
  logic [DUR_BITS-1:0]  r_remain;
  logic [GAP_W-1:0]     r_gap;
  logic [FREQ_BITS-1:0] r_freq;
  logic                 r_chg;

  // r_chg flags an output change in the same edge that updates r_freq
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_remain <= '0;
      r_gap    <= '0;
      r_freq   <= FREQ_SILENT;
      r_chg    <= 1'b0;
    end else begin
      r_chg <= 1'b0;
      if (i_flush) begin
        r_state <= IDLE;
        r_freq  <= FREQ_SILENT;
        r_chg   <= (r_freq != FREQ_SILENT);
      end else begin
        case (r_state)
          IDLE: begin
            if (i_load) begin
              r_state  <= PLAY;
              r_remain <= (i_dur == '0) ? DUR_BITS'(1) : i_dur;
              r_freq   <= i_freq;
              r_chg    <= (i_freq != r_freq);
            end
          end
          PLAY: begin
            if (i_tick) begin
              if (r_remain == DUR_BITS'(1)) begin
                r_freq <= FREQ_SILENT;
                r_chg  <= (r_freq != FREQ_SILENT);
                if (GAP_TICKS > 0) begin
                  r_state <= GAP;
                  r_gap   <= GAP_W'(GAP_TICKS);
                end else begin
                  r_state <= IDLE;
                end
              end else begin
                r_remain <= r_remain - DUR_BITS'(1);
              end
            end
          end
          GAP: begin
            if (i_tick) begin
              if (r_gap == GAP_W'(1)) begin
                r_state <= IDLE;
              end else begin
                r_gap <= r_gap - GAP_W'(1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_freq = r_freq;
  assign o_chg  = r_chg;
  assign o_busy = (r_state != IDLE);

endmodule

// File: rtl/audio_voice_scheduler.sv
// Arbitrates notes from sources A and B onto two voices; B wins, voice 1 fills first.
module audio_voice_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 65000,
  parameter int unsigned DUR_BITS  = 8,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_a,
  input  logic [FREQ_BITS-1:0] freq_a,
  input  logic [DUR_BITS-1:0]  dur_a,
  output logic                 ack_a,
  input  logic                 req_b,
  input  logic [FREQ_BITS-1:0] freq_b,
  input  logic [DUR_BITS-1:0]  dur_b,
  output logic                 ack_b,
  input  logic                 flush,
  output logic [FREQ_BITS-1:0] freq_id1,
  output logic [FREQ_BITS-1:0] freq_id2,
  output logic                 new_f,
  output logic [1:0]           busy
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);

  logic [PRESC_W-1:0]   r_presc;
  logic                 w_tick;
  logic                 w_busy1, w_busy2;
  logic                 w_chg1, w_chg2;
  logic                 w_idle1, w_idle2;
  logic                 w_b_v1, w_b_v2, w_a_v1, w_a_v2;
  logic                 w_load1, w_load2;
  logic [FREQ_BITS-1:0] w_freq1, w_freq2;
  logic [DUR_BITS-1:0]  w_dur1, w_dur2;

  // Free-running tick prescaler; flush leaves it alone
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

  // Grant from registered voice state only; a voice finishing this edge is not yet free
  always_comb begin
    w_idle1 = !w_busy1 && !flush;
    w_idle2 = !w_busy2 && !flush;
    w_b_v1  = req_b && w_idle1;
    w_b_v2  = req_b && !w_idle1 && w_idle2;
    w_a_v1  = req_a && w_idle1 && !req_b;
    w_a_v2  = req_a && w_idle2 && !w_a_v1 && !w_b_v2;
    w_load1 = w_b_v1 || w_a_v1;
    w_load2 = w_b_v2 || w_a_v2;
    w_freq1 = w_b_v1 ? freq_b : freq_a;
    w_dur1  = w_b_v1 ? dur_b  : dur_a;
    w_freq2 = w_b_v2 ? freq_b : freq_a;
    w_dur2  = w_b_v2 ? dur_b  : dur_a;
  end

  assign ack_a = w_a_v1 || w_a_v2;
  assign ack_b = w_b_v1 || w_b_v2;

  audio_voice #(
    .DUR_BITS  (DUR_BITS),
    .GAP_TICKS (GAP_TICKS)
  ) u_voice1 (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load1),
    .i_freq  (w_freq1),
    .i_dur   (w_dur1),
    .i_tick  (w_tick),
    .i_flush (flush),
    .o_freq  (freq_id1),
    .o_chg   (w_chg1),
    .o_busy  (w_busy1)
  );

  audio_voice #(
    .DUR_BITS  (DUR_BITS),
    .GAP_TICKS (GAP_TICKS)
  ) u_voice2 (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load2),
    .i_freq  (w_freq2),
    .i_dur   (w_dur2),
    .i_tick  (w_tick),
    .i_flush (flush),
    .o_freq  (freq_id2),
    .o_chg   (w_chg2),
    .o_busy  (w_busy2)
  );

  // Both change flags are flops, so simultaneous changes merge into one pulse
  assign new_f = w_chg1 || w_chg2;
  assign busy  = {w_busy2, w_busy1};

endmodule
